sat_accum: RTL and testbench
============================

# sat_accum

Streaming frame accumulator that sits directly upstream of the output formatter and reuses the team's 12-bit saturating adder `satadd` as its arithmetic core. It accepts a valid/ready stream of 12-bit samples grouped into frames by `in_last`. It sums each frame with the selected saturation mode and presents one registered result per frame, with a sticky saturation flag and a sample count, on a valid/ready output port.

## Interface
- `CNT_W`, default 8: width of the per-frame sample counter and `out_count`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `mode`  in  2  00 unsigned saturate, 01 signed saturate, 10/11 wrap. Sampled on the first beat of a frame only.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  12  sample.
- `in_last`  in  1  qualifies the final sample of a frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  12  saturated frame sum.
- `out_sat`  out  1  saturation occurred at least once in the frame.
- `out_count`  out  CNT_W  samples in the frame; saturates at 2^CNT_W−1.

## Operation
- **Beat accepted:** `in_valid & in_ready` on a rising edge.
- **FSM states:** IDLE, ACCUM, HOLD. The reset state is IDLE.
- **IDLE:** `in_ready`=1.
  - On a beat: acc ← satadd(0, `in_data`, `mode`), i.e. `in_data`; mode_q ← `mode`; cnt ← 1; sat ← 0.
  - Next state is HOLD if `in_last`, else ACCUM.
- **ACCUM:** `in_ready`=1.
  - On a beat: acc ← satadd(acc, `in_data`, mode_q); cnt ← min(cnt+1, 2^CNT_W−1).
  - sat ← sat | (satadd result ≠ (acc+`in_data`)[11:0]).
  - On `in_last`, go to HOLD.
  - With no beat, all state holds. There is no timeout.
- **HOLD:** `in_ready`=0; `out_valid`=1; `out_data`=acc, `out_sat`=sat, `out_count`=cnt, all stable.
  - On `out_ready`=1, go to IDLE.
- **Saturation is not undone:** later samples accumulate from the clipped value, not from the true sum.
- **Mode stability:** `mode` changes after the first beat of a frame are ignored until the next frame.
- **Wrap mode:** modes 10/11 never set sat.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_sat`=0, `out_count`=0, acc=0, cnt=0, FSM=IDLE.
- **`in_ready` under reset:** 0 while `rst_n`=0. It becomes 1 in the first cycle after deassertion.
- **Reset mid-frame or mid-HOLD:** the partial frame or pending result is discarded with no output.

## Timing
- `in_ready` and `out_valid` are decoded from FSM state only, with no combinational path from `in_valid` or `out_ready`.
- **Latency:** `out_valid` rises in the cycle after the edge that accepts the `in_last` beat.
- **Throughput:** one sample per cycle within a frame. There is a minimum one-cycle bubble per frame, because HOLD accepts no input and the handshake cycle returns to IDLE.
- **Output stability:** outputs are registered and must stay stable while `out_valid`=1 and `out_ready`=0.
- **`out_ready` outside HOLD:** ignored.

## Structure
- **Shared package:** `MODE_USAT`=2'b00, `MODE_SSAT`=2'b01, `MODE_WRAP`=2'b10, the FSM state encoding, and `DATA_W`=12.
- **Sub-module:** one instance of the existing `satadd` (a=acc or 0, b=`in_data`, mode=mode_q or `mode` in IDLE). Its combinational output feeds the acc register.
- **Raw sum for the sat flag:** computed locally.
- No other sub-modules.

## Test plan
- Unsigned clip: mode 00, 0x800 then 0x900 (last) → `out_data`=0xFFF, `out_sat`=1, `out_count`=2.
- Signed clip: mode 01, 0x7F0 then 0x020 (last) → 0x7FF, sat=1. Next frame 0x900 then 0x900 (last) → 0x800, sat=1.
- Clip is sticky: mode 00, 0xF00, 0x200, 0xF00 (last) → 0xFFF, sat=1, count=3. Mode 01, 0x7F0, 0x100, 0x900 (last) → 0x0FF, sat=1.
- Wrap and mode latch: mode 10 on beat 1, switched to 00 on beat 2, 0xFFF then 0x002 (last) → 0x001, sat=0.
- Backpressure and single-beat frame:
  - 0x123 with `in_last` in IDLE, `out_ready` low for 5 cycles → `out_valid` held, `out_data`=0x123, `out_count`=1.
  - During the hold, `in_ready`=0 and offered beats are not consumed.
  - After `out_ready` is raised, IDLE is reached in the next cycle.
- Reset mid-frame: 3 beats without `in_last`, pulse `rst_n` low → all outputs 0. The next frame, 0x005 (last), yields 0x005, count=1, sat=0.

Source files
------------

// File: rtl/sat_accum_pkg.sv
// Shared definitions for the sat_accum frame accumulator: sample width,
// saturation modes and FSM state encoding.
package sat_accum_pkg;

    localparam int DATA_W = 12;

    localparam logic [1:0] MODE_USAT = 2'b00;
    localparam logic [1:0] MODE_SSAT = 2'b01;
    localparam logic [1:0] MODE_WRAP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/sat_accum_satadd.sv
// 12-bit saturating adder: unsigned clip, signed clip, or plain wrap
// (modes 10 and 11 both wrap).
module satadd
    import sat_accum_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W:0] usum;
    logic            s_ovf;

    assign usum  = {1'b0, a_i} + {1'b0, b_i};
    // Signed overflow: operands agree in sign but the result does not.
    assign s_ovf = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                   (usum[DATA_W-1] != a_i[DATA_W-1]);

    always_comb begin
        sum_o = usum[DATA_W-1:0];
        case (mode_i)
            MODE_USAT: if (usum[DATA_W]) sum_o = {DATA_W{1'b1}};
            MODE_SSAT: if (s_ovf) sum_o = a_i[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                        : {1'b0, {(DATA_W-1){1'b1}}};
            default:   sum_o = usum[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/sat_accum.sv
// Streaming frame accumulator: sums each in_last-delimited frame through
// satadd and holds one result (sum, sticky sat flag, count) per frame.
module sat_accum
    import sat_accum_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic [CNT_W-1:0]  out_count,
    output state_t            dbg_state
);

    // Handshake: a beat/result transfers on a rising edge where valid and
    // ready are both 1; ready/valid here depend only on FSM state.
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [1:0]          mode_q, mode_d;

    logic [DATA_W-1:0]   add_a;
    logic [1:0]          add_mode;
    logic [DATA_W-1:0]   add_sum;
    logic [DATA_W-1:0]   raw_sum;
    logic                beat;

    // The first beat of a frame adds to zero using the live mode input.
    assign add_a    = (state_q == ST_IDLE) ? '0   : acc_q;
    assign add_mode = (state_q == ST_IDLE) ? mode : mode_q;
    assign raw_sum  = acc_q + in_data;

    satadd u_satadd (
        .a_i    (add_a),
        .b_i    (in_data),
        .mode_i (add_mode),
        .sum_o  (add_sum)
    );

    assign in_ready  = rst_n && (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = acc_q;
    assign out_sat   = sat_q;
    assign out_count = cnt_q;
    assign dbg_state = state_q;
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d   = add_sum;
                    mode_d  = mode;
                    cnt_d   = CNT_W'(1);
                    sat_d   = 1'b0;
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d = add_sum;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    sat_d = sat_q || (add_sum != raw_sum);
                    if (in_last) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            mode_q  <= MODE_USAT;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_sat_accum.sv
// Bench for sat_accum: frame-level arithmetic model feeding an expected
// queue, with an independent monitor popping on each output handshake.
module tb_sat_accum;
    import sat_accum_pkg::*;

    localparam int CNT_W = 8;
    localparam int EW    = DATA_W + 1 + CNT_W;

    logic              clk;
    logic              rst_n;
    logic [1:0]        mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;
    logic [CNT_W-1:0]  out_count;
    state_t            dbg_state;

    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] stim_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    bit                auto_rdy = 1'b1;

    sat_accum #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame sum from the rules: clip against numeric range, mode fixed by beat 1.
    task automatic push_expected(input logic [1:0] m);
        int acc = 0;
        int cnt = 0;
        bit s = 1'b0;
        foreach (stim_q[i]) begin
            int x = int'(stim_q[i]);
            int t;
            if (m == MODE_USAT) begin
                t = acc + x;
                if (t > 4095) begin t = 4095; s = 1'b1; end
            end else if (m == MODE_SSAT) begin
                int xs = (x >= 2048) ? x - 4096 : x;
                t = acc + xs;
                if (t > 2047) begin t = 2047; s = 1'b1; end
                else if (t < -2048) begin t = -2048; s = 1'b1; end
            end else begin
                t = (acc + x) % 4096;
            end
            acc = t;
            if (cnt < (1 << CNT_W) - 1) cnt++;
        end
        exp_q.push_back({DATA_W'(acc), s, CNT_W'(cnt)});
    endtask

    // ---------------- driver ----------------
    task automatic wait_accept(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: in_ready never rose within 200 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] m, input logic [1:0] later_m, input bit gaps);
        push_expected(m);
        foreach (stim_q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = DATA_W'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            in_last  = (i == stim_q.size() - 1);
            mode     = (i == 0) ? m : later_m;
            wait_accept("beat_accept");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        stim_q.delete();
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic              hold_sat;
    logic [CNT_W-1:0]  hold_cnt;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("stable_data", out_data, hold_data);
                    check("stable_sat", out_sat, hold_sat);
                    check("stable_count", out_count, hold_cnt);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: data %0h with empty queue", out_data);
                    end else begin
                        logic [EW-1:0] e;
                        e = exp_q.pop_front();
                        check("out_data", out_data, e[EW-1 -: DATA_W]);
                        check("out_sat", out_sat, e[CNT_W]);
                        check("out_count", out_count, e[CNT_W-1:0]);
                    end
                end
                prev_hold = out_valid && !out_ready;
                hold_data = out_data;
                hold_sat  = out_sat;
                hold_cnt  = out_count;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        mode     = MODE_USAT;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_count", out_count, 0);
        check("rst_state", dbg_state, ST_IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Unsigned and signed clipping, sticky sat, wrap with mode latch.
        stim_q = '{12'h800, 12'h900};          send_frame(MODE_USAT, MODE_USAT, 0);
        stim_q = '{12'h7F0, 12'h020};          send_frame(MODE_SSAT, MODE_SSAT, 0);
        stim_q = '{12'h900, 12'h900};          send_frame(MODE_SSAT, MODE_SSAT, 0);
        stim_q = '{12'hF00, 12'h200, 12'hF00}; send_frame(MODE_USAT, MODE_USAT, 0);
        stim_q = '{12'h7F0, 12'h100, 12'h900}; send_frame(MODE_SSAT, MODE_SSAT, 0);
        stim_q = '{12'hFFF, 12'h002};          send_frame(MODE_WRAP, MODE_USAT, 0);
        drain();

        // Single-beat frame held under backpressure with a beat offered.
        auto_rdy  = 1'b0;
        out_ready = 1'b0;
        stim_q = '{12'h123};
        send_frame(MODE_USAT, MODE_USAT, 0);
        check("hold_valid_rise", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 12'h7AA;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_data", out_data, 12'h123);
            check("hold_count", out_count, 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_idle", dbg_state, ST_IDLE);
        check("hold_release_valid", out_valid, 0);
        out_ready = 1'b0;
        auto_rdy  = 1'b1;
        drain();

        // Reset in the middle of a frame discards it.
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            in_last  = 1'b0;
            mode     = MODE_USAT;
            wait_accept("midframe_beat");
        end
        in_valid = 1'b0;
        check("midframe_state", dbg_state, ST_ACCUM);
        rst_n = 1'b0;
        #2;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_sat", out_sat, 0);
        check("mid_rst_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stim_q = '{12'h005};
        send_frame(MODE_USAT, MODE_USAT, 0);
        drain();

        // Long frame: sample count saturates at 2^CNT_W-1.
        for (int i = 0; i < 260; i++) stim_q.push_back(DATA_W'($urandom_range(0, 4095)));
        send_frame(MODE_WRAP, MODE_WRAP, 0);
        drain();

        // Randomized frames with random modes, gaps and backpressure.
        for (int f = 0; f < 60; f++) begin
            int len = $urandom_range(1, 6);
            logic [1:0] m0 = 2'($urandom_range(0, 3));
            logic [1:0] m1 = 2'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 1) == 0)
                    stim_q.push_back(DATA_W'($urandom_range(0, 4095)));
                else
                    stim_q.push_back($urandom_range(0, 1) ? 12'h7F0 + DATA_W'($urandom_range(0, 31))
                                                          : 12'h800 + DATA_W'($urandom_range(0, 31)));
            end
            send_frame(m0, m1, 1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
